// File: rtl/vread_multibuf.sv
// vread_multibuf: Versat read unit with N-deep rotating buffers.
// A burst fetch engine fills buffer wbuf from the external databus. In parallel,
// a linear read generator streams the buffer filled by the previous run to out0.
// Optional build macro VREAD_MB_BITREV_EN adds input rd_reverse. When it is set,
// the read address is bit-reversed, which gives FFT ordering.
module vread_multibuf #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int EXT_ADDR_W = 32,
  parameter int NBUF_LOG2  = 1,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  output logic                  err,
  output logic                  databus_valid,
  input  logic                  databus_ready,
  output logic [EXT_ADDR_W-1:0] databus_addr,
  input  logic [DATA_W-1:0]     databus_rdata,
  output logic [LEN_W-1:0]      databus_len,
  input  logic                  databus_last,
  output logic [DATA_W-1:0]     out0,
  output logic                  out_valid,
  input  logic [EXT_ADDR_W-1:0] ext_addr,
  input  logic [ADDR_W:0]       size,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  multibuf,
  input  logic [ADDR_W-1:0]     rd_start,
  input  logic [ADDR_W-1:0]     rd_incr,
  input  logic [ADDR_W:0]       rd_iter,
`ifdef VREAD_MB_BITREV_EN
  input  logic                  rd_reverse,
`endif
  input  logic [7:0]            rd_delay
);

  // A single-buffer build still carries a 1-bit buffer index, which is held at 0.
  localparam int BUF_W     = (NBUF_LOG2 > 0) ? NBUF_LOG2 : 1;
  localparam int RAM_AW    = ADDR_W + NBUF_LOG2;
  localparam int RAM_DEPTH = 2 ** RAM_AW;
  localparam int CNT_W     = (ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W;
  localparam logic [EXT_ADDR_W-1:0] BYTES = EXT_ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_BURST, S_FDONE} state_t;

  state_t                r_state, w_next_state;

  // Fetch-side registers
  logic [BUF_W-1:0]      r_wbuf;
  logic [EXT_ADDR_W-1:0] r_ext_addr;
  logic [ADDR_W:0]       r_remaining;
  logic [ADDR_W:0]       r_words_done;
  logic [LEN_W-1:0]      r_blen_eff;
  logic [ADDR_W-1:0]     r_waddr;
  logic [EXT_ADDR_W-1:0] r_bus_addr;
  logic [LEN_W-1:0]      r_bus_len;
  logic                  r_done_a;

  // Read-side registers
  logic                  r_rd_busy;
  logic [7:0]            r_rd_dcnt;
  logic [ADDR_W:0]       r_rd_left;
  logic [ADDR_W-1:0]     r_raddr;
  logic [ADDR_W-1:0]     r_rd_incr;
  logic [BUF_W-1:0]      r_rbuf;
  logic                  r_done_b;
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out0;

  logic                  r_done;
  logic                  r_err;

  logic [DATA_W-1:0]     r_mem [RAM_DEPTH];

  logic                  w_accept;
  logic                  w_beat;
  logic                  w_we;
  logic                  w_rd_issue;
  logic [CNT_W-1:0]      w_rem_c, w_blen_c, w_beats;
  logic [ADDR_W-1:0]     w_raddr_eff;
  logic [RAM_AW-1:0]     w_waddr_full, w_raddr_full;

  assign w_accept   = run && (r_state == S_IDLE) && !r_rd_busy;
  assign w_beat     = (r_state == S_BURST) && databus_ready;
  // Beats arriving after the run's word count is exhausted are not stored.
  assign w_we       = w_beat && (r_remaining != '0);
  assign w_rd_issue = r_rd_busy && (r_rd_dcnt == 8'd0) && (r_rd_left != '0);

  assign w_rem_c  = CNT_W'(r_remaining);
  assign w_blen_c = CNT_W'(r_blen_eff);
  assign w_beats  = (w_blen_c < w_rem_c) ? w_blen_c : w_rem_c;

`ifdef VREAD_MB_BITREV_EN
  logic r_rd_reverse;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  assign w_raddr_eff = r_rd_reverse ? bitrev(r_raddr) : r_raddr;
`else
  assign w_raddr_eff = r_raddr;
`endif

  assign w_waddr_full = RAM_AW'({r_wbuf, r_waddr});
  assign w_raddr_full = RAM_AW'({r_rbuf, w_raddr_eff});

  assign databus_valid = (r_state == S_BURST);
  assign databus_addr  = r_bus_addr;
  assign databus_len   = r_bus_len;
  assign out0          = r_out0;
  assign out_valid     = r_out_valid;
  assign done          = r_done;
  assign err           = r_err;

  // Fetch FSM state register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked block uses non-blocking assignments, so all registers sample pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Fetch FSM next-state logic
  always_comb begin
    // NOTE: the default assignment here keeps every path assigned, so no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = (size == '0) ? S_FDONE : S_SETUP;
      S_SETUP: w_next_state = S_BURST;
      S_BURST: begin
        // An early last simply closes the burst. The word count is already exact
        // because remaining is decremented on every stored beat.
        if (w_beat && databus_last)
          w_next_state = (r_remaining > (ADDR_W+1)'(1)) ? S_SETUP : S_FDONE;
      end
      S_FDONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Fetch datapath: latch config on run, compute burst request, count beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbuf       <= '0;
      r_ext_addr   <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_blen_eff   <= '0;
      r_waddr      <= '0;
      r_bus_addr   <= '0;
      r_bus_len    <= '0;
      r_done_a     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ext_addr   <= ext_addr;
        r_remaining  <= size;
        r_words_done <= '0;
        r_blen_eff   <= (burst_len == '0) ? LEN_W'(1) : burst_len;
        r_waddr      <= '0;
        r_done_a     <= 1'b0;
        r_wbuf       <= (multibuf && NBUF_LOG2 > 0) ? r_wbuf + 1'b1 : '0;
      end
      if (r_state == S_SETUP) begin
        r_bus_len  <= LEN_W'(w_beats - CNT_W'(1));
        r_bus_addr <= r_ext_addr + EXT_ADDR_W'(r_words_done) * BYTES;
      end
      if (w_we) begin
        r_waddr      <= r_waddr + 1'b1;
        r_remaining  <= r_remaining - 1'b1;
        r_words_done <= r_words_done + 1'b1;
      end
      if (r_state == S_FDONE) r_done_a <= 1'b1;
    end
  end

  // Buffer RAM write port
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; its contents are defined by the fetch before any read.
    if (w_we) r_mem[w_waddr_full] <= databus_rdata;
  end

  // Read engine: delay, then linear address generation with registered RAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_busy   <= 1'b0;
      r_rd_dcnt   <= '0;
      r_rd_left   <= '0;
      r_raddr     <= '0;
      r_rd_incr   <= '0;
      r_rbuf      <= '0;
      r_done_b    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out0      <= '0;
`ifdef VREAD_MB_BITREV_EN
      r_rd_reverse <= 1'b0;
`endif
    end else if (w_accept) begin
      r_rd_busy   <= 1'b1;
      r_rd_dcnt   <= rd_delay;
      r_rd_left   <= rd_iter;
      r_raddr     <= rd_start;
      r_rd_incr   <= rd_incr;
      r_rbuf      <= r_wbuf;
      r_done_b    <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef VREAD_MB_BITREV_EN
      r_rd_reverse <= rd_reverse;
`endif
    end else begin
      r_out_valid <= 1'b0;
      if (r_rd_busy) begin
        if (r_rd_dcnt != 8'd0) r_rd_dcnt <= r_rd_dcnt - 8'd1;
        if (r_rd_left == '0 && r_rd_dcnt < 8'd2) begin
          // With nothing to stream, the read side completes as the delay ends.
          r_rd_busy <= 1'b0;
          r_done_b  <= 1'b1;
        end else if (w_rd_issue) begin
          r_out0      <= r_mem[w_raddr_full];
          r_out_valid <= 1'b1;
          r_raddr     <= r_raddr + r_rd_incr;
          r_rd_left   <= r_rd_left - 1'b1;
          if (r_rd_left == (ADDR_W+1)'(1)) begin
            r_rd_busy <= 1'b0;
            r_done_b  <= 1'b1;
          end
        end
      end
    end
  end

  // Combined done and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_accept ? 1'b0 : (r_done_a & r_done_b);
      if (run && !w_accept) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vread_multibuf.sv
// Testbench for vread_multibuf. A bus slave model answers bursts with an
// address-derived data pattern. Expected bursts and streamed words are queued
// when each run is launched and are compared as the DUT produces them.
module tb_vread_multibuf;
  localparam int DATA_W = 32, ADDR_W = 10, EXT_ADDR_W = 32, LEN_W = 8;

  logic clk = 1'b0;
  logic rst, run, done, err, databus_valid, databus_ready, databus_last, out_valid, multibuf;
  logic [EXT_ADDR_W-1:0] databus_addr, ext_addr;
  logic [DATA_W-1:0]     databus_rdata, out0;
  logic [LEN_W-1:0]      databus_len, burst_len;
  logic [ADDR_W:0]       size, rd_iter;
  logic [ADDR_W-1:0]     rd_start, rd_incr;
  logic [7:0]            rd_delay;

  always #5 clk = ~clk;

  vread_multibuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .EXT_ADDR_W(EXT_ADDR_W),
                   .NBUF_LOG2(1), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .run(run), .done(done), .err(err),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_rdata(databus_rdata),
    .databus_len(databus_len), .databus_last(databus_last),
    .out0(out0), .out_valid(out_valid), .ext_addr(ext_addr), .size(size),
    .burst_len(burst_len), .multibuf(multibuf), .rd_start(rd_start),
    .rd_incr(rd_incr), .rd_iter(rd_iter),
`ifdef VREAD_MB_BITREV_EN
    .rd_reverse(1'b0),
`endif
    .rd_delay(rd_delay));

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  burst_t      exp_bursts[$];
  logic [31:0] exp_words[$];
  logic [31:0] m_mem [2][1024];
  int          m_wbuf = 0;
  int          n_cmp = 0, n_bad = 0;
  int          total_beats = 0;
  int          beat_idx = 0;
  int          cut_beats = 0;
  bit          ready_rand = 0;
  logic        prev_valid = 1'b0;
  burst_t      cur_burst;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Bus slave: drives response signals away from the active edge
  always @(negedge clk) begin
    databus_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    databus_rdata = pat(databus_addr + 32'(beat_idx) * 32'd4);
    databus_last  = (beat_idx == int'(databus_len)) ||
                    (cut_beats > 0 && beat_idx == cut_beats - 1);
  end

  // Slave beat counter
  always @(posedge clk or posedge rst) begin
    if (rst) beat_idx <= 0;
    else if (databus_valid && databus_ready) begin
      beat_idx    <= databus_last ? 0 : beat_idx + 1;
      total_beats <= total_beats + 1;
    end
  end

  // Scoreboard: burst requests and streamed words
  always @(negedge clk) begin
    if (!rst) begin
      if (databus_valid && !prev_valid) begin
        n_cmp++;
        if (exp_bursts.size() == 0) begin
          n_bad++;
          $display("FAIL burst_unexpected got addr=%h len=%0d, none expected", databus_addr, databus_len);
        end else begin
          cur_burst = exp_bursts.pop_front();
          if ({databus_addr, databus_len} !== cur_burst) begin
            n_bad++;
            $display("FAIL burst_req got addr=%h len=%0d expected addr=%h len=%0d",
                     databus_addr, databus_len, cur_burst.addr, cur_burst.len);
          end
        end
      end else if (databus_valid && prev_valid) begin
        n_cmp++;
        if ({databus_addr, databus_len} !== cur_burst) begin
          n_bad++;
          $display("FAIL burst_hold got addr=%h len=%0d expected addr=%h len=%0d",
                   databus_addr, databus_len, cur_burst.addr, cur_burst.len);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (exp_words.size() == 0) begin
          n_bad++;
          $display("FAIL stream_unexpected got out0=%h, none expected", out0);
        end else begin
          logic [31:0] w;
          w = exp_words.pop_front();
          if (out0 !== w) begin
            n_bad++;
            $display("FAIL stream_word got %h expected %h", out0, w);
          end
        end
      end
    end
    prev_valid = databus_valid;
  end

  // Queue expectations from an independent model, then pulse run
  task automatic start_run(input logic [31:0] ea, input int sz, input int bl, input bit mb,
                           input int rs, input int ri, input int rit, input int rd);
    int rb, rem, dn, b, got, blen;
    burst_t e;
    rb = m_wbuf;
    for (int k = 0; k < rit; k++) exp_words.push_back(m_mem[rb][(rs + k * ri) % 1024]);
    m_wbuf = mb ? (m_wbuf + 1) % 2 : 0;
    for (int k = 0; k < sz; k++) m_mem[m_wbuf][k] = pat(ea + 32'(k) * 32'd4);
    blen = (bl == 0) ? 1 : bl;
    rem = sz;
    dn = 0;
    while (rem > 0) begin
      b = (blen < rem) ? blen : rem;
      e.addr = ea + 32'(dn) * 32'd4;
      e.len  = 8'(b - 1);
      exp_bursts.push_back(e);
      got = (cut_beats > 0 && cut_beats < b) ? cut_beats : b;
      dn += got;
      rem -= got;
    end
    @(negedge clk);
    ext_addr = ea; size = 11'(sz); burst_len = 8'(bl); multibuf = mb;
    rd_start = 10'(rs); rd_incr = 10'(ri); rd_iter = 11'(rit); rd_delay = 8'(rd);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; ext_addr = '0; size = '0; burst_len = '0; multibuf = 1'b0;
    rd_start = '0; rd_incr = '0; rd_iter = '0; rd_delay = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 7;
    if (done !== 1'b0)          begin n_bad++; $display("FAIL reset_done got %b expected 0", done); end
    if (err !== 1'b0)           begin n_bad++; $display("FAIL reset_err got %b expected 0", err); end
    if (databus_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b expected 0", databus_valid); end
    if (databus_addr !== '0)    begin n_bad++; $display("FAIL reset_addr got %h expected 0", databus_addr); end
    if (databus_len !== '0)     begin n_bad++; $display("FAIL reset_len got %0d expected 0", databus_len); end
    if (out_valid !== 1'b0)     begin n_bad++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    if (out0 !== '0)            begin n_bad++; $display("FAIL reset_out0 got %h expected 0", out0); end
  endtask

  task automatic test_fetch_basic;
    bit ok;
    int b0;
    b0 = total_beats;
    start_run(32'h1000, 16, 4, 1'b1, 0, 1, 0, 0);
    wait_done(300, ok);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL fetch_basic_done got timeout expected done=1"); end
    if (total_beats - b0 != 16) begin n_bad++; $display("FAIL fetch_basic_beats got %0d expected 16", total_beats - b0); end
    if (exp_bursts.size() != 0) begin n_bad++; $display("FAIL fetch_basic_bursts got %0d left expected 0", exp_bursts.size()); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL fetch_basic_done_hold got %b expected 1", done); end
  endtask

  task automatic test_pingpong;
    bit ok;
    ready_rand = 1;
    // Stream of run 1's buffer while fetching 64 words with bus stalls
    start_run(32'h2000, 64, 16, 1'b1, 0, 1, 16, 2);
    wait_done(2000, ok);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL pingpong_done got timeout expected done=1"); end
    if (exp_words.size() != 0)  begin n_bad++; $display("FAIL pingpong_stream got %0d left expected 0", exp_words.size()); end
    if (exp_bursts.size() != 0) begin n_bad++; $display("FAIL pingpong_bursts got %0d left expected 0", exp_bursts.size()); end
    ready_rand = 0;
    // Stream outlasts the fetch here, and burst_len=0 acts as 1
    start_run(32'h3000, 16, 0, 1'b1, 5, 3, 10, 40);
    wait_done(500, ok);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL late_stream_done got timeout expected done=1"); end
    if (exp_words.size() != 0)  begin n_bad++; $display("FAIL late_stream_words got %0d left expected 0", exp_words.size()); end
    if (exp_bursts.size() != 0) begin n_bad++; $display("FAIL late_stream_bursts got %0d left expected 0", exp_bursts.size()); end
  endtask

  task automatic test_short_burst;
    bit ok;
    start_run(32'h4000, 10, 4, 1'b0, 12, 1, 4, 0);
    wait_done(300, ok);
    n_cmp += 4;
    if (!ok) begin n_bad++; $display("FAIL short_done got timeout expected done=1"); end
    if (databus_addr !== 32'h4000 + 32'd32) begin n_bad++; $display("FAIL short_final_addr got %h expected %h", databus_addr, 32'h4020); end
    if (databus_len !== 8'd1) begin n_bad++; $display("FAIL short_final_len got %0d expected 1", databus_len); end
    if (exp_words.size() != 0) begin n_bad++; $display("FAIL short_stream got %0d left expected 0", exp_words.size()); end
  endtask

  task automatic test_early_last;
    bit ok;
    int b0;
    b0 = total_beats;
    cut_beats = 2;
    start_run(32'h5000, 10, 4, 1'b1, 0, 1, 0, 0);
    wait_done(300, ok);
    cut_beats = 0;
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL early_last_done got timeout expected done=1"); end
    if (total_beats - b0 != 10) begin n_bad++; $display("FAIL early_last_beats got %0d expected 10", total_beats - b0); end
    if (exp_bursts.size() != 0) begin n_bad++; $display("FAIL early_last_bursts got %0d left expected 0", exp_bursts.size()); end
    // Stream the buffer just filled to confirm data landed at the right addresses
    start_run(32'h0, 0, 1, 1'b1, 0, 1, 10, 0);
    wait_done(100, ok);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL early_last_read_done got timeout expected done=1"); end
    if (exp_words.size() != 0) begin n_bad++; $display("FAIL early_last_read got %0d left expected 0", exp_words.size()); end
  endtask

  task automatic test_size_zero;
    bit saw_valid;
    saw_valid = 0;
    start_run(32'h0, 0, 1, 1'b1, 0, 1, 0, 5);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (databus_valid) saw_valid = 1;
      n_cmp++;
      if (done !== (c >= 6)) begin n_bad++; $display("FAIL size_zero_done cycle %0d got %b expected %b", c, done, c >= 6); end
    end
    n_cmp++;
    if (saw_valid) begin n_bad++; $display("FAIL size_zero_valid got 1 expected 0"); end
  endtask

  task automatic test_err_and_reset;
    bit ok, found;
    int b0;
    ready_rand = 1;
    b0 = total_beats;
    start_run(32'h6000, 32, 8, 1'b1, 0, 1, 0, 0);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin @(negedge clk); if (databus_valid) found = 1; end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n_cmp += 2;
    if (!found) begin n_bad++; $display("FAIL err_burst_start got timeout expected valid=1"); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b expected 1", err); end
    wait_done(1000, ok);
    n_cmp += 4;
    if (!ok) begin n_bad++; $display("FAIL err_done got timeout expected done=1"); end
    if (total_beats - b0 != 32) begin n_bad++; $display("FAIL err_beats got %0d expected 32", total_beats - b0); end
    if (exp_bursts.size() != 0) begin n_bad++; $display("FAIL err_bursts got %0d left expected 0", exp_bursts.size()); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b expected 1", err); end
    // Reset in the middle of a burst
    start_run(32'h7000, 32, 8, 1'b1, 0, 1, 0, 0);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin @(negedge clk); if (databus_valid) found = 1; end
    #2 rst = 1'b1;
    #1;
    n_cmp += 4;
    if (!found) begin n_bad++; $display("FAIL rst_burst_start got timeout expected valid=1"); end
    if (databus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b expected 0", databus_valid); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b expected 0", done); end
    if (err !== 1'b0)  begin n_bad++; $display("FAIL rst_err got %b expected 0", err); end
    exp_bursts.delete();
    exp_words.delete();
    m_wbuf = 0;
    ready_rand = 0;
    @(negedge clk);
    rst = 1'b0;
    // Buffer index must restart from 0 after reset
    start_run(32'h8000, 8, 8, 1'b1, 0, 1, 0, 0);
    wait_done(100, ok);
    start_run(32'h0, 0, 1, 1'b1, 0, 1, 8, 0);
    wait_done(100, ok);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL post_rst_done got timeout expected done=1"); end
    if (exp_words.size() != 0) begin n_bad++; $display("FAIL post_rst_stream got %0d left expected 0", exp_words.size()); end
  endtask

`ifdef VREAD_MB_BITREV_EN
  logic        rv_run, rv_done, rv_err, rv_valid, rv_ready, rv_last, rv_ovalid, rv_mb, rv_rev;
  logic [31:0] rv_addr, rv_rdata, rv_out0, rv_ext;
  logic [7:0]  rv_len, rv_blen, rv_delay;
  logic [3:0]  rv_size, rv_iter;
  logic [2:0]  rv_start, rv_incr;
  int          rv_beat = 0;

  vread_multibuf #(.DATA_W(32), .ADDR_W(3), .EXT_ADDR_W(32), .NBUF_LOG2(1), .LEN_W(8)) u_rev (
    .clk(clk), .rst(rst), .run(rv_run), .done(rv_done), .err(rv_err),
    .databus_valid(rv_valid), .databus_ready(rv_ready), .databus_addr(rv_addr),
    .databus_rdata(rv_rdata), .databus_len(rv_len), .databus_last(rv_last),
    .out0(rv_out0), .out_valid(rv_ovalid), .ext_addr(rv_ext), .size(rv_size),
    .burst_len(rv_blen), .multibuf(rv_mb), .rd_start(rv_start), .rd_incr(rv_incr),
    .rd_iter(rv_iter), .rd_reverse(rv_rev), .rd_delay(rv_delay));

  always @(negedge clk) begin
    rv_ready = 1'b1;
    rv_rdata = pat(rv_addr + 32'(rv_beat) * 32'd4);
    rv_last  = (rv_beat == int'(rv_len));
  end

  always @(posedge clk or posedge rst)
    if (rst) rv_beat <= 0;
    else if (rv_valid && rv_ready) rv_beat <= rv_last ? 0 : rv_beat + 1;

  task automatic test_bitrev;
    int ord[8];
    int k;
    logic [31:0] want;
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};
    @(negedge clk);
    rv_ext = 32'h0; rv_size = 4'd8; rv_blen = 8'd8; rv_mb = 1'b0; rv_rev = 1'b0;
    rv_start = 3'd0; rv_incr = 3'd1; rv_iter = 4'd0; rv_delay = 8'd0; rv_run = 1'b1;
    @(negedge clk);
    rv_run = 1'b0;
    for (int c = 0; c < 60 && !rv_done; c++) @(negedge clk);
    rv_size = 4'd0; rv_iter = 4'd8; rv_rev = 1'b1; rv_run = 1'b1;
    @(negedge clk);
    rv_run = 1'b0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rv_ovalid && k < 8) begin
        want = pat(32'(ord[k]) * 32'd4);
        n_cmp++;
        if (rv_out0 !== want) begin n_bad++; $display("FAIL bitrev_word %0d got %h expected %h", k, rv_out0, want); end
        k++;
      end
    end
    n_cmp++;
    if (k != 8) begin n_bad++; $display("FAIL bitrev_count got %0d expected 8", k); end
  endtask
`endif

  initial begin
`ifdef VREAD_MB_BITREV_EN
    rv_run = 1'b0; rv_ext = '0; rv_size = '0; rv_blen = '0; rv_mb = 1'b0; rv_rev = 1'b0;
    rv_start = '0; rv_incr = '0; rv_iter = '0; rv_delay = '0;
`endif
    test_reset();
    test_fetch_basic();
    test_pingpong();
    test_short_burst();
    test_early_last();
    test_size_zero();
    test_err_and_reset();
`ifdef VREAD_MB_BITREV_EN
    test_bitrev();
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vread_multibuf.md
Name: vread_multibuf

Overview:
- Next-generation Versat read unit.
- Fetches `size` words from the external native databus into an internal 2-port RAM.
- Data is fetched in bursts of up to `burst_len` beats.
- The RAM is split into 2^NBUF_LOG2 rotating buffers, generalising ping-pong to N-deep buffering.
- A linear read generator streams the previous run's buffer to `out0` for the datapath.

Parameters:
- DATA_W, 32: data word width.
- ADDR_W, 10: word address width within one buffer.
- EXT_ADDR_W, 32: external byte-address width.
- NBUF_LOG2, 1: log2 of buffer count; 0 means single buffer.
- LEN_W, 8: burst-length width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  one-cycle start pulse.
- done  out  1  fetch and stream both complete.
- err  out  1  sticky flag: run arrived while busy.
- databus_valid  out  1  request/beat-accept valid.
- databus_ready  in  1  beat delivered.
- databus_addr  out  EXT_ADDR_W  burst start byte address.
- databus_rdata  in  DATA_W  read beat.
- databus_len  out  LEN_W  beats in current burst minus 1.
- databus_last  in  1  final beat of burst.
- out0  out  DATA_W  streamed word.
- out_valid  out  1  out0 qualifier.
- ext_addr  in  EXT_ADDR_W  external start byte address.
- size  in  ADDR_W+1  words to fetch (0..2^ADDR_W).
- burst_len  in  LEN_W  max beats per burst; 0 is treated as 1.
- multibuf  in  1  enable buffer rotation.
- rd_start  in  ADDR_W  first read address.
- rd_incr  in  ADDR_W  read address increment.
- rd_iter  in  ADDR_W+1  words to stream.
- rd_delay  in  8  cycles from run to first read.

Behaviour:
- Reset values:
  - done=0, err=0, databus_valid=0, databus_addr=0, databus_len=0, out_valid=0, out0=0.
  - wbuf=0, FSM=IDLE.
- run acceptance:
  - run is accepted only when FSM=IDLE and the read engine is idle.
  - run while busy is ignored and sets err; err is cleared by rst only.
- On accepted run:
  - Latch all configs.
  - done<=0.
  - If multibuf: wbuf<=wbuf+1 mod 2^NBUF_LOG2; otherwise wbuf<=0.
  - rbuf<=old wbuf, i.e. the read side streams the data fetched in the previous run.
- Fetch FSM: IDLE -> SETUP -> BURST -> (SETUP | FDONE).
  - SETUP (1 cycle, valid=0):
    - beats = min(burst_len_eff, remaining).
    - databus_len = beats-1.
    - databus_addr = ext_addr + words_done*(DATA_W/8), with wrap modulo 2^EXT_ADDR_W.
  - BURST:
    - databus_valid=1; addr and len are held stable.
    - Each cycle with valid&&ready writes rdata to RAM[{wbuf,waddr}], then waddr++ and remaining--.
    - valid&&ready&&last: go to SETUP if remaining>0, else FDONE.
    - last before the expected beat count: the burst is closed and remaining is recomputed from the beats actually received.
  - size=0: IDLE -> FDONE the cycle after run with no bus request.
  - FDONE: doneA=1; return to IDLE.
- Read engine:
  - Waits rd_delay cycles after run.
  - Then issues rd_iter reads at address rd_start + k*rd_incr (mod 2^ADDR_W, within rbuf).
  - out0/out_valid follow each issue by 1 cycle (RAM latency 1).
  - doneB is set on the cycle the last out_valid is high.
  - rd_iter=0: doneB is set at the end of the delay period.
- done = doneA & doneB, registered; it stays 1 until the next accepted run.
- Write/read collision on the same RAM address is impossible by construction while multibuf=1 and NBUF_LOG2>=1. With multibuf=0 it is software's responsibility.
- rst mid-burst: all state returns to reset values at once. The bus slave is responsible for dropping the outstanding burst.

Optional Feature:
- Macro VREAD_MB_BITREV_EN.
- Defined: adds input `rd_reverse` (1 bit). When rd_reverse=1 the ADDR_W-bit read address is bit-reversed before the buffer index is prepended, for FFT ordering.
- Undefined: the port is absent and addresses are always linear.

Test Plan:
- size=16, burst_len=4, ext_addr=0x1000, slave ready every cycle:
  - 4 bursts at 0x1000, 0x1010, 0x1020, 0x1030, each with len=3.
  - RAM words 0..15 in buffer 1 match the slave pattern.
  - doneA set after the 16th beat.
- Two runs with multibuf=1, NBUF_LOG2=1, rd_start=0, rd_incr=1, rd_iter=16:
  - The second run streams the first run's data on out0 while fetching into the other buffer.
  - done rises only after both the fetch and the stream finish.
- size=10, burst_len=4:
  - Bursts carry len 3, 3, 1.
  - Final databus_addr = ext_addr+32.
- size=0, rd_iter=0, rd_delay=5: no databus_valid ever; done=1 six cycles after run.
- run pulsed during BURST: ignored, err=1, and the transfer completes unchanged. Then assert rst mid-burst: valid=0, done=0, err=0 immediately.
- With VREAD_MB_BITREV_EN, ADDR_W=3, rd_reverse=1, rd_incr=1, rd_iter=8: the read order is 0,4,2,6,1,5,3,7.
